keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 3x3 push-button key matrix and reports debounced key presses to the game core as a 4-bit key index with a one-cycle valid strobe.
- An internal divider sets the column scan rate. An optional seven-segment decoder shows the last key.
- Sits between the GPIO matrix pins and the hit-recording logic. The game core compares the key index against the lit LED position.

Parameters:
- SCAN_DIV, 49_999: divider reload value; one scan tick every SCAN_DIV+1 clk cycles (1 ms at 50 MHz).
- DEBOUNCE_SCANS, 4: consecutive full 3-column scans a key must be seen before it is reported (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous active-low reset.
- row  input  3  matrix row sense, active-low (pulled up externally).
- column  output  3  column drive, active-low one-hot.
- valid_key  output  1  one-cycle pulse when a new debounced key is reported.
- key  output  4  key index 0..8 = row*3 + column index; 4'hF = none since reset.
- hex  output  7  active-low seven-segment digit of key; present only with KEYPAD_HEX_EN.

Behaviour:
- Reset (clear low, asynchronous), all values apply immediately:
  - column = 3'b110
  - key = 4'hF
  - valid_key = 0
  - divider count = SCAN_DIV
  - state IDLE
  - debounce count 0
  - candidate = 4'hF
- Divider:
  - Counts down every clk cycle. At 0 it reloads SCAN_DIV and asserts tick for one cycle.
  - First tick occurs SCAN_DIV+1 cycles after reset release.
- Scan:
  - Column sequence is 110 -> 101 -> 011 -> 110 (column index 0,1,2).
  - On each tick, first sample row for the currently driven column, then advance the column. The full tick period is the settling time.
  - A column sample is a hit only if exactly one row bit is 0. Zero or several low rows count as no hit for that column.
  - Row index: bit0 = 0, bit1 = 1, bit2 = 2.
  - A scan completes on the tick that samples column index 2.
  - The scan result is the first hit in column order 0,1,2, else none.
- States, updated at scan completion:
  - IDLE:
    - Result none: stay.
    - Result k: candidate = k, count = 1. Go to DEBOUNCE, or straight to REPORT if DEBOUNCE_SCANS = 1.
  - DEBOUNCE:
    - Result equals candidate: count increments. When count reaches DEBOUNCE_SCANS, go to REPORT.
    - Result differs (including none): go to IDLE. The new result is not adopted in that same scan.
  - REPORT: lasts one clk cycle. key = candidate, valid_key = 1, then go to HELD.
  - HELD: a scan result of none returns to IDLE. Any other result keeps HELD and produces no report, even if it is a different key.
- Latency: valid_key rises on the clk edge after the scan-completing tick that satisfies debounce.
- Key output: key holds its value between reports. It changes only at REPORT or reset.
- Reset mid-debounce or while HELD: the press is discarded. A key still held after reset is reported again after a full debounce.
- valid_key is never high for two consecutive cycles.

Optional Feature:
- Macro KEYPAD_HEX_EN.
- When defined:
  - Port hex exists and is combinationally decoded from key, active-low.
  - Digits 0..8 use standard patterns (0 = 7'b1000000, 8 = 7'b0000000).
  - 4'hF and any value above 8 give blank, 7'b1111111.
- When undefined: no hex port and no decoder logic. All other behaviour is identical.

Decomposition:
- Package keypad_pkg holds:
  - NO_KEY = 4'hF
  - COL_IDLE = 3'b110
  - state encoding IDLE/DEBOUNCE/REPORT/HELD
  - the seven-segment constant table and BLANK = 7'b1111111
- One sub-module, scan_divider: down-counter with reload and tick output, using clk and clear.
- The seven-segment decode is a function in the package, not a module.

Test Plan (SCAN_DIV=3, DEBOUNCE_SCANS=2):
- Reset: clear low mid-scan -> column=110, key=F, valid_key=0 immediately. After release, first column change at cycle 4.
- Single press: row=110 held while column 101 is driven, for 2 scans -> one valid_key pulse, key=1. key stays 1 after release. A second press of the same key after release is reported again.
- Bounce: hit present in scan 1, absent in scan 2, present in scans 3-4 -> exactly one pulse, after scan 4, key as pressed.
- Multi-row: row=100 on column 0 -> no report. Row 110 on column 0 plus row 101 on column 2 -> key=0 (first in scan order).
- Held then switch: key 4 held, then key 8 pressed without a none scan -> no second pulse. Release all, press 8 for 2 scans -> pulse, key=8.
- KEYPAD_HEX_EN: key=F -> hex=1111111. key=8 -> hex=0000000. key=0 -> hex=1000000.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants for the 3x3 keypad scanner: key codes, column idle pattern,
// FSM state encoding and the active-low seven-segment table (used with KEYPAD_HEX_EN).
package keypad_pkg;

  localparam logic [3:0] NO_KEY   = 4'hF;
  localparam logic [2:0] COL_IDLE = 3'b110;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_REPORT   = 2'd2;
  localparam logic [1:0] ST_HELD     = 2'd3;

  localparam logic [6:0] BLANK = 7'b1111111;

  // Segment order gfedcba, active-low; entry 8 first so SEG_TABLE[k] is digit k.
  localparam logic [8:0][6:0] SEG_TABLE = {
    7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] k);
    if (k <= 4'd8) return SEG_TABLE[k];
    return BLANK;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_divider.sv
// Scan-rate divider: down-counter that reloads SCAN_DIV at zero and flags a
// one-cycle tick, giving one tick every SCAN_DIV+1 clocks.
module scan_divider #(
  parameter int unsigned SCAN_DIV = 49_999
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  localparam int unsigned    CW     = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam logic [CW-1:0]  RELOAD = CW'(SCAN_DIV);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_count <= RELOAD;
    end else if (r_count == '0) begin
      r_count <= RELOAD;
    end else begin
      r_count <= r_count - CW'(1);
    end
  end

  assign tick = (r_count == '0);

endmodule

// File: rtl/keypad_scanner.sv
// 3x3 key matrix scanner with debounce and one-cycle valid strobe.
// Optional KEYPAD_HEX_EN adds an active-low seven-segment output of the last key.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 49_999,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] row,
  output logic [2:0] column,
  output logic       valid_key,
  output logic [3:0] key
`ifdef KEYPAD_HEX_EN
  ,
  output logic [6:0] hex
`endif
);
  import keypad_pkg::*;

  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

  logic       w_tick;
  logic [1:0] w_col_idx;
  logic       w_row_hit;
  logic [1:0] w_row_idx;
  logic [3:0] w_col_key;
  logic [3:0] w_result;
  logic       w_scan_done;

  logic [2:0] r_column;
  logic [3:0] r_partial;
  logic [1:0] r_state;
  logic [3:0] r_cand;
  logic [3:0] r_deb_count;
  logic [3:0] r_key;
  logic       r_valid;

  scan_divider #(.SCAN_DIV(SCAN_DIV)) u_div (
    .clk   (clk),
    .clear (clear),
    .tick  (w_tick)
  );

  always_comb begin
    case (r_column)
      3'b101:  w_col_idx = 2'd1;
      3'b011:  w_col_idx = 2'd2;
      default: w_col_idx = 2'd0;
    endcase
  end

  // Only a single low row counts as a hit; ghosting/multi-press gives nothing.
  always_comb begin
    w_row_hit = 1'b0;
    w_row_idx = 2'd0;
    case (row)
      3'b110: begin w_row_hit = 1'b1; w_row_idx = 2'd0; end
      3'b101: begin w_row_hit = 1'b1; w_row_idx = 2'd1; end
      3'b011: begin w_row_hit = 1'b1; w_row_idx = 2'd2; end
      default: ;
    endcase
  end

  assign w_col_key = ({2'b00, w_row_idx} * 4'd3) + {2'b00, w_col_idx};

  // Scan result so far including the column sampled this tick; earliest column wins.
  always_comb begin
    w_result = NO_KEY;
    if (w_col_idx != 2'd0 && r_partial != NO_KEY) begin
      w_result = r_partial;
    end else if (w_row_hit) begin
      w_result = w_col_key;
    end
  end

  assign w_scan_done = w_tick && (w_col_idx == 2'd2);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_column  <= COL_IDLE;
      r_partial <= NO_KEY;
    end else if (w_tick) begin
      r_column  <= {r_column[1:0], r_column[2]};
      r_partial <= w_result;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state     <= ST_IDLE;
      r_cand      <= NO_KEY;
      r_deb_count <= 4'd0;
      r_key       <= NO_KEY;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_scan_done && w_result != NO_KEY) begin
            r_cand      <= w_result;
            r_deb_count <= 4'd1;
            if (DEB_TARGET == 4'd1) begin
              r_state <= ST_REPORT;
              r_key   <= w_result;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (w_scan_done) begin
            if (w_result == r_cand) begin
              r_deb_count <= r_deb_count + 4'd1;
              if (r_deb_count + 4'd1 == DEB_TARGET) begin
                r_state <= ST_REPORT;
                r_key   <= r_cand;
                r_valid <= 1'b1;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_REPORT: r_state <= ST_HELD;
        ST_HELD: begin
          if (w_scan_done && w_result == NO_KEY) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign column    = r_column;
  assign key       = r_key;
  assign valid_key = r_valid;

`ifdef KEYPAD_HEX_EN
  assign hex = seg7_decode(r_key);
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner (SCAN_DIV=3, DEBOUNCE_SCANS=2) with an emulated key
// matrix and a scan-level reference model of the debounce/report rules.
module tb_keypad_scanner;

  localparam int SCAN_DIV   = 3;
  localparam int DEB        = 2;
  localparam int SCAN_CYC   = 3 * (SCAN_DIV + 1);

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] row;
  logic [2:0] column;
  logic       valid_key;
  logic [3:0] key;
`ifdef KEYPAD_HEX_EN
  logic [6:0] hex;
`endif

  logic [8:0] pressed = '0;
  logic       last_valid = 1'b0;
  int         checks = 0;
  int         errors = 0;

  int         m_run_len = 0;
  logic [3:0] m_run_key = 4'hF;
  bit         m_held = 1'b0;
  logic [3:0] m_key = 4'hF;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .clear     (clear),
    .row       (row),
    .column    (column),
    .valid_key (valid_key),
    .key       (key)
`ifdef KEYPAD_HEX_EN
    ,
    .hex       (hex)
`endif
  );

  always #5 clk = ~clk;

  // Key k = r*3+c shorts row r to column c while pressed.
  always_comb begin
    row = 3'b111;
    for (int c = 0; c < 3; c++)
      if (!column[c])
        for (int r = 0; r < 3; r++)
          if (pressed[r*3+c]) row[r] = 1'b0;
  end

  function automatic logic [3:0] ref_result(input logic [8:0] p);
    int n;
    int hr;
    for (int c = 0; c < 3; c++) begin
      n  = 0;
      hr = 0;
      for (int r = 0; r < 3; r++)
        if (p[r*3+c]) begin n++; hr = r; end
      if (n == 1) return 4'(hr * 3 + c);
    end
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_run_len = 0;
    m_run_key = 4'hF;
    m_held    = 1'b0;
    m_key     = 4'hF;
  endtask

  // One completed scan: a run of identical results reaching DEB reports once;
  // a broken run is dropped without adopting the breaking result.
  task automatic model_scan(input logic [3:0] res, output int exp_pulses);
    exp_pulses = 0;
    if (m_held) begin
      if (res == 4'hF) m_held = 1'b0;
    end else if (m_run_len > 0 && res == m_run_key) begin
      m_run_len++;
    end else if (m_run_len > 0) begin
      m_run_len = 0;
    end else if (res != 4'hF) begin
      m_run_key = res;
      m_run_len = 1;
    end
    if (!m_held && m_run_len == DEB) begin
      exp_pulses = 1;
      m_key      = m_run_key;
      m_held     = 1'b1;
      m_run_len  = 0;
    end
  endtask

  // Called at a scan boundary (negedge, column 110 about to be sampled next tick).
  task automatic run_scan(input logic [8:0] p, output int pulses, output logic [3:0] k_end,
                          output logic [2:0] col_start, output bit dbl);
    col_start = column;
    pressed   = p;
    pulses    = 0;
    dbl       = 1'b0;
    repeat (SCAN_CYC) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_key) begin
        pulses++;
        if (last_valid) dbl = 1'b1;
      end
      last_valid = valid_key;
    end
    k_end = key;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    last_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [8:0] pats [5];
    int pulses, exp_p;
    logic [3:0] k_obs;
    logic [2:0] c0;
    bit dbl;
    clear   = 1'b0;
    pressed = '0;
    repeat (2) @(negedge clk);
    checks++; if (column !== 3'b110) begin errors++; $display("FAIL reset_column: got %b expected 110", column); end
    checks++; if (key !== 4'hF) begin errors++; $display("FAIL reset_key: got %h expected f", key); end
    checks++; if (valid_key !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_key); end
    clear = 1'b1;
    model_reset();
    for (int e = 1; e <= SCAN_CYC; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == SCAN_DIV) begin
        checks++; if (column !== 3'b110) begin errors++; $display("FAIL first_tick_early: cycle %0d column %b expected 110", e, column); end
      end
      if (e == SCAN_DIV + 1) begin
        checks++; if (column !== 3'b101) begin errors++; $display("FAIL first_tick: cycle %0d column %b expected 101", e, column); end
      end
    end
    model_scan(ref_result(9'h000), exp_p);
    pats = '{9'h010, 9'h010, 9'h010, 9'h010, 9'h000};
    for (int i = 0; i < 2; i++) begin
      run_scan(pats[i], pulses, k_obs, c0, dbl);
      model_scan(ref_result(pats[i]), exp_p);
      checks++; if (pulses !== exp_p) begin errors++; $display("FAIL reset_pre_pulses scan %0d: got %0d expected %0d", i, pulses, exp_p); end
      checks++; if (k_obs !== m_key) begin errors++; $display("FAIL reset_pre_key scan %0d: got %h expected %h", i, k_obs, m_key); end
    end
    repeat (5) begin @(posedge clk); @(negedge clk); end
    #2 clear = 1'b0;
    #1;
    checks++; if (column !== 3'b110) begin errors++; $display("FAIL midscan_reset_column: got %b expected 110", column); end
    checks++; if (key !== 4'hF) begin errors++; $display("FAIL midscan_reset_key: got %h expected f", key); end
    checks++; if (valid_key !== 1'b0) begin errors++; $display("FAIL midscan_reset_valid: got %b expected 0", valid_key); end
    repeat (2) @(negedge clk);
    clear = 1'b1;
    last_valid = 1'b0;
    model_reset();
    for (int i = 2; i < 5; i++) begin
      run_scan(pats[i], pulses, k_obs, c0, dbl);
      model_scan(ref_result(pats[i]), exp_p);
      checks++; if (pulses !== exp_p) begin errors++; $display("FAIL reset_post_pulses scan %0d: got %0d expected %0d", i, pulses, exp_p); end
      checks++; if (k_obs !== m_key) begin errors++; $display("FAIL reset_post_key scan %0d: got %h expected %h", i, k_obs, m_key); end
    end
    checks++; if (key !== 4'h4) begin errors++; $display("FAIL reset_rereport_key: got %h expected 4", key); end
  endtask

  task automatic test_single_press();
    logic [8:0] pats [6];
    int pulses, exp_p, total;
    logic [3:0] k_obs;
    logic [2:0] c0;
    bit dbl;
    pats  = '{9'h000, 9'h002, 9'h002, 9'h000, 9'h002, 9'h002};
    total = 0;
    foreach (pats[i]) begin
      run_scan(pats[i], pulses, k_obs, c0, dbl);
      model_scan(ref_result(pats[i]), exp_p);
      total += pulses;
      checks++; if (pulses !== exp_p) begin errors++; $display("FAIL single_pulses scan %0d: got %0d expected %0d", i, pulses, exp_p); end
      checks++; if (k_obs !== m_key) begin errors++; $display("FAIL single_key scan %0d: got %h expected %h", i, k_obs, m_key); end
    end
    checks++; if (total !== 2) begin errors++; $display("FAIL single_total: got %0d expected 2", total); end
    checks++; if (key !== 4'h1) begin errors++; $display("FAIL single_final_key: got %h expected 1", key); end
  endtask

  task automatic test_bounce();
    logic [8:0] pats [6];
    int pulses, exp_p, total;
    logic [3:0] k_obs;
    logic [2:0] c0;
    bit dbl;
    pats  = '{9'h000, 9'h080, 9'h000, 9'h080, 9'h080, 9'h000};
    total = 0;
    foreach (pats[i]) begin
      run_scan(pats[i], pulses, k_obs, c0, dbl);
      model_scan(ref_result(pats[i]), exp_p);
      total += pulses;
      checks++; if (pulses !== exp_p) begin errors++; $display("FAIL bounce_pulses scan %0d: got %0d expected %0d", i, pulses, exp_p); end
      checks++; if (k_obs !== m_key) begin errors++; $display("FAIL bounce_key scan %0d: got %h expected %h", i, k_obs, m_key); end
    end
    checks++; if (total !== 1) begin errors++; $display("FAIL bounce_total: got %0d expected 1", total); end
    checks++; if (key !== 4'h7) begin errors++; $display("FAIL bounce_final_key: got %h expected 7", key); end
  endtask

  task automatic test_multi_row();
    logic [8:0] pats [7];
    int pulses, exp_p, total;
    logic [3:0] k_obs;
    logic [2:0] c0;
    bit dbl;
    pats  = '{9'h000, 9'h009, 9'h009, 9'h009, 9'h000, 9'h021, 9'h021};
    total = 0;
    foreach (pats[i]) begin
      run_scan(pats[i], pulses, k_obs, c0, dbl);
      model_scan(ref_result(pats[i]), exp_p);
      total += pulses;
      checks++; if (pulses !== exp_p) begin errors++; $display("FAIL multirow_pulses scan %0d: got %0d expected %0d", i, pulses, exp_p); end
      checks++; if (k_obs !== m_key) begin errors++; $display("FAIL multirow_key scan %0d: got %h expected %h", i, k_obs, m_key); end
    end
    checks++; if (total !== 1) begin errors++; $display("FAIL multirow_total: got %0d expected 1", total); end
    checks++; if (key !== 4'h0) begin errors++; $display("FAIL multirow_final_key: got %h expected 0", key); end
  endtask

  task automatic test_held_switch();
    logic [8:0] pats [9];
    int pulses, exp_p, total;
    logic [3:0] k_obs;
    logic [2:0] c0;
    bit dbl;
    pats  = '{9'h000, 9'h010, 9'h010, 9'h100, 9'h100, 9'h100, 9'h000, 9'h100, 9'h100};
    total = 0;
    foreach (pats[i]) begin
      run_scan(pats[i], pulses, k_obs, c0, dbl);
      model_scan(ref_result(pats[i]), exp_p);
      total += pulses;
      checks++; if (pulses !== exp_p) begin errors++; $display("FAIL held_pulses scan %0d: got %0d expected %0d", i, pulses, exp_p); end
      checks++; if (k_obs !== m_key) begin errors++; $display("FAIL held_key scan %0d: got %h expected %h", i, k_obs, m_key); end
      if (i == 5) begin
        checks++; if (k_obs !== 4'h4) begin errors++; $display("FAIL held_no_switch: got %h expected 4", k_obs); end
      end
    end
    checks++; if (total !== 2) begin errors++; $display("FAIL held_total: got %0d expected 2", total); end
    checks++; if (key !== 4'h8) begin errors++; $display("FAIL held_final_key: got %h expected 8", key); end
  endtask

  task automatic test_random();
    logic [8:0] p;
    int pulses, exp_p, hold, kind;
    logic [3:0] k_obs;
    logic [2:0] c0;
    bit dbl;
    repeat (40) begin
      kind = int'($urandom_range(0, 3));
      p    = '0;
      if (kind == 1 || kind == 2) p[$urandom_range(0, 8)] = 1'b1;
      if (kind == 3) begin
        p[$urandom_range(0, 8)] = 1'b1;
        p[$urandom_range(0, 8)] = 1'b1;
      end
      hold = int'($urandom_range(1, 3));
      repeat (hold) begin
        run_scan(p, pulses, k_obs, c0, dbl);
        model_scan(ref_result(p), exp_p);
        checks++; if (pulses !== exp_p) begin errors++; $display("FAIL rand_pulses keys=%b: got %0d expected %0d", p, pulses, exp_p); end
        checks++; if (k_obs !== m_key) begin errors++; $display("FAIL rand_key keys=%b: got %h expected %h", p, k_obs, m_key); end
        checks++; if (c0 !== 3'b110) begin errors++; $display("FAIL rand_scan_phase: column %b at scan start expected 110", c0); end
        checks++; if (dbl !== 1'b0) begin errors++; $display("FAIL rand_valid_width: valid_key high two cycles running (got %b expected 0)", dbl); end
      end
    end
  endtask

`ifdef KEYPAD_HEX_EN
  task automatic test_hex();
    logic [3:0] k_obs;
    logic [2:0] c0;
    int pulses, exp_p;
    bit dbl;
    do_reset();
    #1;
    checks++; if (hex !== 7'b1111111) begin errors++; $display("FAIL hex_blank: got %b expected 1111111", hex); end
    repeat (2) begin
      run_scan(9'h100, pulses, k_obs, c0, dbl);
      model_scan(ref_result(9'h100), exp_p);
    end
    checks++; if (hex !== 7'b0000000) begin errors++; $display("FAIL hex_8: got %b expected 0000000", hex); end
    run_scan(9'h000, pulses, k_obs, c0, dbl);
    model_scan(ref_result(9'h000), exp_p);
    repeat (2) begin
      run_scan(9'h001, pulses, k_obs, c0, dbl);
      model_scan(ref_result(9'h001), exp_p);
    end
    checks++; if (hex !== 7'b1000000) begin errors++; $display("FAIL hex_0: got %b expected 1000000", hex); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_row();
    test_held_switch();
    test_random();
`ifdef KEYPAD_HEX_EN
    test_hex();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
